reg_file_2r1w: RTL and testbench

REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

---
 rtl/reg_file_2r1w.sv | 46 ++++
 tb/tb_reg_file_2r1w.sv | 139 +++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file. Register 0 always reads as zero. A reset loads each register with its own index.
// Define REG_FILE_BYPASS_EN to forward write data to the read ports before the clock edge.
module reg_file_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic [ADDR_WIDTH-1:0] read_reg_num1,
    input  logic [ADDR_WIDTH-1:0] read_reg_num2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    input  logic                  regwrite,
    input  logic                  clock,
    input  logic                  reset
);

    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NREGS];

    // Slot 0 is never written, and the read muxes mask it.
    // Resetting slot 0 keeps every element driven.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= DATA_WIDTH'(i);
        end else if (regwrite && write_reg != '0) begin
            regs[write_reg] <= write_data;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    logic fwd_en;
    assign fwd_en = regwrite && !reset && (write_reg != '0);

    assign read_data1 = (read_reg_num1 == '0) ? '0 :
                        (fwd_en && read_reg_num1 == write_reg) ? write_data : regs[read_reg_num1];
    assign read_data2 = (read_reg_num2 == '0) ? '0 :
                        (fwd_en && read_reg_num2 == write_reg) ? write_data : regs[read_reg_num2];
`else
    assign read_data1 = (read_reg_num1 == '0) ? '0 : regs[read_reg_num1];
    assign read_data2 = (read_reg_num2 == '0) ? '0 : regs[read_reg_num2];
`endif

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed self-checking bench for reg_file_2r1w, with hand-computed expected values.
// Build with REG_FILE_BYPASS_EN defined to check the forwarding path instead of old-value reads.
module tb_reg_file_2r1w;

    logic [4:0]  read_reg_num1, read_reg_num2, write_reg;
    logic [31:0] write_data, read_data1, read_data2;
    logic        regwrite, clock, reset;

    int checks = 0;
    int failures = 0;

    reg_file_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .read_reg_num1(read_reg_num1),
        .read_reg_num2(read_reg_num2),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .regwrite     (regwrite),
        .clock        (clock),
        .reset        (reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Read the same address on both ports. Both ports must agree.
    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        read_reg_num1 = a;
        read_reg_num2 = a;
        #1;
        chk({tag, "_p1"}, read_data1, exp);
        chk({tag, "_p2"}, read_data2, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        write_reg  = a;
        write_data = d;
        regwrite   = 1'b1;
        @(posedge clock);
        #1;
        regwrite   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; regwrite = 1'b0;
        write_reg = '0; write_data = '0;
        read_reg_num1 = '0; read_reg_num2 = '0;
        #1;
        chk("pre_reset_r0_p1", read_data1, 32'd0);
        chk("pre_reset_r0_p2", read_data2, 32'd0);

        @(posedge clock); #1;
        reset = 1'b0;

        rd("rst_r0", 5'd0, 32'd0);
        rd("rst_r1", 5'd1, 32'd1);
        rd("rst_r5", 5'd5, 32'd5);
        rd("rst_r15", 5'd15, 32'd15);
        rd("rst_r31", 5'd31, 32'd31);

        // Read during write to the same address, before the edge.
        write_reg = 5'd5; write_data = 32'd100; regwrite = 1'b1;
        read_reg_num1 = 5'd5; read_reg_num2 = 5'd6;
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("rdw_before_edge", read_data1, 32'd100);
`else
        chk("rdw_before_edge", read_data1, 32'd5);
`endif
        chk("rdw_other_port", read_data2, 32'd6);
        @(posedge clock); #1;
        regwrite = 1'b0;
        chk("rdw_after_edge", read_data1, 32'd100);
        chk("neighbour_r6", read_data2, 32'd6);

        wr(5'd10, 32'd250);
        wr(5'd20, 32'd500);
        rd("wr_r10", 5'd10, 32'd250);
        rd("wr_r20", 5'd20, 32'd500);
        wr(5'd0, 32'd999);
        rd("wr_r0_discard", 5'd0, 32'd0);

        wr(5'd8, 32'd88);
        wr(5'd12, 32'd144);
        read_reg_num1 = 5'd8; read_reg_num2 = 5'd12;
        #1;
        chk("dual_r8", read_data1, 32'd88);
        chk("dual_r12", read_data2, 32'd144);
        read_reg_num1 = 5'd5; read_reg_num2 = 5'd10;
        #1;
        chk("keep_r5", read_data1, 32'd100);
        chk("keep_r10", read_data2, 32'd250);

        // A write with regwrite low must not change anything.
        write_reg = 5'd15; write_data = 32'd777; regwrite = 1'b0;
        @(posedge clock); #1;
        rd("nowe_r15", 5'd15, 32'd15);

        wr(5'd29, 32'hFFFF_FFFF);
        wr(5'd28, 32'h8000_0000);
        wr(5'd31, 32'd1000);
        wr(5'd30, 32'd750);
        rd("full_r29", 5'd29, 32'hFFFF_FFFF);
        rd("full_r28", 5'd28, 32'h8000_0000);
        rd("full_r31", 5'd31, 32'd1000);
        rd("full_r30", 5'd30, 32'd750);

`ifdef REG_FILE_BYPASS_EN
        write_reg = 5'd7; write_data = 32'd42; regwrite = 1'b1; reset = 1'b0;
        read_reg_num1 = 5'd7; read_reg_num2 = 5'd0;
        #1;
        chk("bypass_r7", read_data1, 32'd42);
        chk("bypass_r0", read_data2, 32'd0);
        regwrite = 1'b0;
        #1;
`endif

        // Reset takes priority over a simultaneous write.
        reset = 1'b1; regwrite = 1'b1; write_reg = 5'd7; write_data = 32'd42;
        @(posedge clock); #1;
        reset = 1'b0; regwrite = 1'b0;
        rd("rst_prio_r7", 5'd7, 32'd7);
        rd("rst_again_r5", 5'd5, 32'd5);
        rd("rst_again_r29", 5'd29, 32'd29);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
